countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of count, load_value and the period register.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port load  input  1  loads load_value into count and the period register.
REQ-005 SHALL have port load_value  input  DATA_WIDTH  countdown start value, sampled only when load=1.
REQ-006 SHALL have port start  input  1  start or resume counting.
REQ-007 SHALL have port stop  input  1  pause counting.
REQ-008 SHALL have port reload_mode  input  1  when 1, the timer auto-reloads on expiry instead of stopping; sampled every edge.
REQ-009 SHALL have port count  output  DATA_WIDTH  current remaining count, registered.
REQ-010 SHALL have port running  output  1  1 exactly when state=RUN.
REQ-011 SHALL have port expired  output  1  1 exactly when state=EXPIRED.
REQ-012 SHALL have port alarm  output  1  registered one-cycle pulse on each expiry or auto-reload.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSED and EXPIRED.
REQ-014 SHALL apply event priority on each edge: resetn low, then load, then stop, then start, then RUN decrement.
REQ-015 SHALL, on load, set count=load_value and period=load_value, enter IDLE, clear expired, and hold alarm=0, from any state.
REQ-016 SHALL, on stop in RUN with no load, enter PAUSED and hold count with no decrement on that edge; stop in any other state has no effect.
REQ-017 SHALL, on start in IDLE or PAUSED with count!=0 and no stop or load, enter RUN; count holds on that edge and the first decrement occurs on the next edge.
REQ-018 SHALL ignore start when count=0, in RUN, or in EXPIRED.
REQ-019 SHALL, in RUN with no load or stop and count>1, set count=count-1 and alarm=0.
REQ-020 SHALL, in RUN with no load or stop, count=1 and reload_mode=0, set count=0, enter EXPIRED and set alarm=1 for one cycle.
REQ-021 SHALL, in RUN with no load or stop, count=1 and reload_mode=1, set count=period, remain in RUN and set alarm=1 for one cycle, giving an alarm period of exactly period cycles.
REQ-022 SHALL hold count=0 and expired=1 in EXPIRED until load or resetn.
REQ-023 SHALL never decrement count below 0 and never wrap to all-ones.
REQ-024 SHALL ensure that simultaneous start and stop never results in RUN (stop wins).
REQ-025 SHALL ensure that load coinciding with a would-be expiry produces no alarm and leaves expired=0.
REQ-026 SHALL set alarm=0 on every edge not covered by REQ-020 or REQ-021.

Reset
REQ-027 SHALL, on resetn=0 at a rising edge, set count=0, period=0, state=IDLE, running=0, expired=0 and alarm=0, overriding all other inputs including mid-run.
REQ-028 SHALL ensure that after reset start has no effect until a non-zero load.

Verification
REQ-029 SHALL cover: load 5, then start -> running=1, count 5,4,3,2,1,0 on successive edges; alarm=1 only in the cycle count first reads 0; expired stays 1.
REQ-030 SHALL cover: load 6, start, stop when count=3, idle 4 cycles, start -> count holds 3 while PAUSED, then 3,2,1,0, single alarm.
REQ-031 SHALL cover: load 4, start and stop asserted together in IDLE -> state stays IDLE, count stays 4, running=0.
REQ-032 SHALL cover: reload_mode=1, load 3, start -> count 3,2,1,3,2,1,3...; alarm every 3rd cycle, coincident with count=3; expired never 1.
REQ-033 SHALL cover: load 9, start, load with load_value=7 when count=1 -> count=7, IDLE, alarm=0, expired=0.
REQ-034 SHALL cover: load 8, start, resetn low at count=5 -> next cycle count=0 with all outputs 0; a following start leaves running=0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the controller drives load/start/stop,
// and the timer returns count and status flags.
interface countdown_timer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  load;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  start;
  logic                  stop;
  logic                  reload_mode;
  logic [DATA_WIDTH-1:0] count;
  logic                  running;
  logic                  expired;
  logic                  alarm;

  modport master (
    output load, load_value, start, stop, reload_mode,
    input  count, running, expired, alarm
  );

  modport slave (
    input  load, load_value, start, stop, reload_mode,
    output count, running, expired, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, optional auto-reload and a one-cycle alarm
// pulse on every expiry or reload.
module countdown_timer #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic                  alarm_q, alarm_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      alarm_q  <= alarm_d;
    end
  end

  // Priority: load, then stop, then start, then the RUN decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    alarm_d  = 1'b0;

    if (bus.load) begin
      count_d  = bus.load_value;
      period_d = bus.load_value;
      state_d  = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else if (bus.start && (state_q == IDLE || state_q == PAUSED) && count_q != '0) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (count_q > DATA_WIDTH'(1)) begin
        count_d = count_q - DATA_WIDTH'(1);
      end else if (count_q == DATA_WIDTH'(1)) begin
        alarm_d = 1'b1;
        if (bus.reload_mode) begin
          count_d = period_q;
        end else begin
          count_d = '0;
          state_d = EXPIRED;
        end
      end else begin
        // A zero count in RUN is unreachable; settle into EXPIRED rather than wrap.
        state_d = EXPIRED;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == RUN);
  assign bus.expired = (state_q == EXPIRED);
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each step drives one cycle of inputs, queues the
// hand-derived outputs expected after the next rising edge, then pops and checks them.
module tb_countdown_timer;

  localparam int unsigned DW = 16;

  typedef struct {
    string   tag;
    int      count;
    logic    running;
    logic    expired;
    logic    alarm;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  countdown_timer_if #(.DATA_WIDTH(DW)) bus();

  countdown_timer #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rn, input logic ld, input int lv,
                      input logic st, input logic sp, input logic rl,
                      input int ec, input logic er, input logic ee, input logic ea);
    exp_t e;
    exp_t got;
    resetn          = rn;
    bus.load        = ld;
    bus.load_value  = DW'(lv);
    bus.start       = st;
    bus.stop        = sp;
    bus.reload_mode = rl;
    e.tag = tag; e.count = ec; e.running = er; e.expired = ee; e.alarm = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (bus.count === DW'(got.count)) else begin
      errors++;
      $error("FAIL %s.count got=%0d exp=%0d", got.tag, bus.count, got.count);
    end
    checks++;
    assert (bus.running === got.running) else begin
      errors++;
      $error("FAIL %s.running got=%b exp=%b", got.tag, bus.running, got.running);
    end
    checks++;
    assert (bus.expired === got.expired) else begin
      errors++;
      $error("FAIL %s.expired got=%b exp=%b", got.tag, bus.expired, got.expired);
    end
    checks++;
    assert (bus.alarm === got.alarm) else begin
      errors++;
      $error("FAIL %s.alarm got=%b exp=%b", got.tag, bus.alarm, got.alarm);
    end
  endtask

  // Plain cycle with no control inputs asserted.
  task automatic idle(input string tag, input logic rl, input int ec,
                      input logic er, input logic ee, input logic ea);
    step(tag, 1, 0, 0, 0, 0, rl, ec, er, ee, ea);
  endtask

  initial begin
    resetn = 1'b0;
    bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.reload_mode = 1'b0;

    // Reset, and start with a zero count is ignored.
    step("reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("start_after_reset", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Basic one-shot countdown from 5.
    step("basic_load", 1, 1, 5, 0, 0, 0, 5, 0, 0, 0);
    step("basic_start", 1, 0, 0, 1, 0, 0, 5, 1, 0, 0);
    idle("basic_4", 0, 4, 1, 0, 0);
    idle("basic_3", 0, 3, 1, 0, 0);
    idle("basic_2", 0, 2, 1, 0, 0);
    idle("basic_1", 0, 1, 1, 0, 0);
    idle("basic_0", 0, 0, 0, 1, 1);
    idle("basic_hold", 0, 0, 0, 1, 0);
    step("expired_start", 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    step("expired_stop", 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    idle("expired_hold", 0, 0, 0, 1, 0);

    // Pause at 3, sit paused, then resume.
    step("pause_load", 1, 1, 6, 0, 0, 0, 6, 0, 0, 0);
    step("pause_start", 1, 0, 0, 1, 0, 0, 6, 1, 0, 0);
    idle("pause_5", 0, 5, 1, 0, 0);
    idle("pause_4", 0, 4, 1, 0, 0);
    idle("pause_3", 0, 3, 1, 0, 0);
    step("pause_stop", 1, 0, 0, 0, 1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle("paused_hold", 0, 3, 0, 0, 0);
    step("resume_start", 1, 0, 0, 1, 0, 0, 3, 1, 0, 0);
    idle("resume_2", 0, 2, 1, 0, 0);
    idle("resume_1", 0, 1, 1, 0, 0);
    idle("resume_0", 0, 0, 0, 1, 1);
    idle("resume_hold", 0, 0, 0, 1, 0);

    // Simultaneous start and stop in IDLE: stop wins.
    step("ss_load", 1, 1, 4, 0, 0, 0, 4, 0, 0, 0);
    step("ss_both", 1, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    idle("ss_after", 0, 4, 0, 0, 0);

    // Auto-reload with period 3; start while running is ignored.
    step("rl_load", 1, 1, 3, 0, 0, 1, 3, 0, 0, 0);
    step("rl_start", 1, 0, 0, 1, 0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle("rl_2", 1, 2, 1, 0, 0);
      idle("rl_1", 1, 1, 1, 0, 0);
      idle("rl_reload", 1, 3, 1, 0, 1);
    end
    step("rl_start_running", 1, 0, 0, 1, 0, 1, 2, 1, 0, 0);
    step("rl_stop", 1, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    idle("rl_paused", 0, 2, 0, 0, 0);

    // Load lands on the would-be expiry edge.
    step("le_load", 1, 1, 9, 0, 0, 0, 9, 0, 0, 0);
    step("le_start", 1, 0, 0, 1, 0, 0, 9, 1, 0, 0);
    for (int c = 8; c >= 1; c--) idle("le_count", 0, c, 1, 0, 0);
    step("le_reload", 1, 1, 7, 0, 0, 0, 7, 0, 0, 0);
    idle("le_after", 0, 7, 0, 0, 0);

    // Reset mid-run, then start is ignored.
    step("rr_load", 1, 1, 8, 0, 0, 0, 8, 0, 0, 0);
    step("rr_start", 1, 0, 0, 1, 0, 0, 8, 1, 0, 0);
    idle("rr_7", 0, 7, 1, 0, 0);
    idle("rr_6", 0, 6, 1, 0, 0);
    idle("rr_5", 0, 5, 1, 0, 0);
    step("rr_reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("rr_start_after", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
